// File: rtl/lsi_vic_if.sv
// Vector-fetch channel between processor (master) and the interrupt controller (slave).
// Signals: wbi_stb_i strobe, wbi_ack_o acknowledge, wbi_dat_o 16-bit vector.
interface lsi_vic_if;
  logic        wbi_stb_i;
  logic        wbi_ack_o;
  logic [15:0] wbi_dat_o;

  modport master (
    output wbi_stb_i,
    input  wbi_ack_o,
    input  wbi_dat_o
  );

  modport slave (
    input  wbi_stb_i,
    output wbi_ack_o,
    output wbi_dat_o
  );
endinterface

// File: rtl/lsi_vic.sv
// Vectored interrupt controller: fixed-priority arbitration, vector fetch, per-source ack.
// Ports: vm_clk_p, vm_rst_n, irq_rq, irq_vec, irq_ack, vm_virq, wbi (slave).
// Define LSI_VIC_LATCH_EN for edge-latched requests; default is level mode.
module lsi_vic #(
  parameter int          NIRQ     = 4,
  parameter logic [15:0] VEC_NONE = 16'o000000
) (
  input  logic              vm_clk_p,
  input  logic              vm_rst_n,
  input  logic [NIRQ-1:0]   irq_rq,
  input  logic [16*NIRQ-1:0] irq_vec,
  output logic [NIRQ-1:0]   irq_ack,
  output logic              vm_virq,
  lsi_vic_if.slave          wbi
);

  localparam int SW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACK  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t          state_q;
  logic [SW-1:0]   sel_q;
  logic            sel_valid_q;
  logic            ack_q;
  logic [15:0]     dat_q;
  logic [NIRQ-1:0] irq_ack_q;
  logic [NIRQ-1:0] mask_q;
  logic            virq_q;
  logic [NIRQ-1:0] pend;

`ifdef LSI_VIC_LATCH_EN
  logic [NIRQ-1:0] rq_q;
  logic [NIRQ-1:0] lat_q;
  logic [NIRQ-1:0] rise;

  assign rise = irq_rq & ~rq_q;

  // A fresh edge in the ack cycle re-arms the flag.
  always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
    if (!vm_rst_n) begin
      rq_q  <= '0;
      lat_q <= '0;
    end else begin
      rq_q  <= irq_rq;
      lat_q <= (lat_q & ~irq_ack_q) | rise;
    end
  end

  // Edge seen this cycle already counts for arbitration.
  assign pend = lat_q | rise;
`else
  assign pend = irq_rq;
`endif

  logic [SW-1:0]   win;
  logic            win_ok;
  logic [15:0]     win_vec;

  // Scan high to low so the lowest pending index wins.
  always_comb begin
    win     = '0;
    win_ok  = 1'b0;
    win_vec = VEC_NONE;
    for (int k = NIRQ - 1; k >= 0; k--) begin
      if (pend[k]) begin
        win     = SW'(k);
        win_ok  = 1'b1;
        win_vec = irq_vec[16*k +: 16];
      end
    end
  end

  always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
    if (!vm_rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      sel_valid_q <= 1'b0;
      ack_q       <= 1'b0;
      dat_q       <= '0;
      irq_ack_q   <= '0;
      mask_q      <= '0;
      virq_q      <= 1'b0;
    end else begin
      irq_ack_q <= '0;
      virq_q    <= |(pend & ~mask_q);
      unique case (state_q)
        IDLE: begin
          if (wbi.wbi_stb_i) begin
            sel_q       <= win;
            sel_valid_q <= win_ok;
            dat_q       <= win_vec;
            ack_q       <= 1'b1;
            mask_q      <= win_ok ? (NIRQ'(1) << win) : '0;
            state_q     <= ACK;
          end
        end
        ACK: begin
          ack_q <= 1'b0;
          if (wbi.wbi_stb_i) begin
            if (sel_valid_q)
              irq_ack_q <= NIRQ'(1) << sel_q;
            state_q <= WAIT;
          end else begin
            mask_q  <= '0;
            state_q <= IDLE;
          end
        end
        WAIT: begin
          if (!wbi.wbi_stb_i) begin
            mask_q  <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign irq_ack       = irq_ack_q;
  assign vm_virq       = virq_q;
  assign wbi.wbi_ack_o = ack_q;
  assign wbi.wbi_dat_o = dat_q;

endmodule
